// File: rtl/stage_skid_reg.sv
// ---------------------------------------------------------------------------
// stage_skid_reg
//
// Two-entry pipeline stage register with a skid buffer. The head entry
// ("main") drives the downstream outputs directly from flops. The second
// entry ("skid") catches the one beat that can arrive while downstream is
// stalled. Because of that, in_ready is a pure register output and has no
// combinational path from out_ready. Both entries are cleared by a
// synchronous flush, which is used to kill beats on a control hazard.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous active-high reset
//   in_valid    in   1       upstream beat present
//   in_ready    out  1       stage can accept a beat (= skid entry empty)
//   in_ctrl     in   CTRL_W  upstream control payload
//   in_data     in   DATA_W  upstream data payload
//   flush       in   1       kill every held and incoming beat
//   out_valid   out  1       head entry valid
//   out_ready   in   1       downstream takes the head this cycle
//   out_ctrl    out  CTRL_W  head control payload, zero when out_valid=0
//   out_data    out  DATA_W  head data payload
//   occupancy   out  2       number of entries held (0..2)
//   bubble_cnt  out  CNT_W   cycles downstream was ready but saw no beat
//   flush_cnt   out  CNT_W   flushes that discarded at least one entry
// ---------------------------------------------------------------------------
module stage_skid_reg #(
  parameter int CTRL_W             = 24,
  parameter int DATA_W             = 128,
  parameter int CNT_W              = 16,
  parameter bit CLR_DATA_ON_BUBBLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Entry storage. The stage state (EMPTY / ONE / TWO) is encoded by the two
  // valid bits; skid_valid_q=1 always implies main_valid_q=1.
  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

  logic accept;
  logic pop;
  logic bubble_inc;
  logic flush_inc;

  // in_ready is the inverse of a flop, so it settles right after the edge
  // and does not depend on out_ready in the same cycle.
  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign pop       = main_valid_q & out_ready;

  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // ---------------------------------------------------------------------
  // Entry next-state logic. Clearing an entry always zeroes valid and ctrl.
  // Data is zeroed only when CLR_DATA_ON_BUBBLE is set. Otherwise it holds,
  // which avoids toggling a wide data bus on every bubble. Input payloads
  // are only looked at on accept, so X on them while idle stays outside.
  // ---------------------------------------------------------------------
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Flush wins over accept and pop. A pop in this cycle was already
      // seen downstream, and the offered beat is dropped.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      if (CLR_DATA_ON_BUBBLE) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (!main_valid_q) begin
      // EMPTY
      if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end
    end else if (!skid_valid_q) begin
      // ONE
      if (accept && pop) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end else if (pop) begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
        if (CLR_DATA_ON_BUBBLE) begin
          main_data_d = '0;
        end
      end
    end else begin
      // TWO: in_ready is low, so only a pop can move things
      if (pop) begin
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
        if (CLR_DATA_ON_BUBBLE) begin
          skid_data_d = '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Performance counters, saturating at all-ones. A flush cycle is not
  // counted as a bubble even if downstream was ready with nothing to take.
  // ---------------------------------------------------------------------
  assign bubble_inc = ~main_valid_q & out_ready & ~flush;
  assign flush_inc  = flush & (main_valid_q | skid_valid_q);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (bubble_inc && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
    if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_stage_skid_reg
//
// Directed bench for stage_skid_reg. The main instance uses
// CLR_DATA_ON_BUBBLE=1 and 4-bit counters. A second instance with
// CLR_DATA_ON_BUBBLE=0 shares the same inputs and shows that data holds.
// A table of single-cycle vectors covers streaming, backpressure and flush.
// Hand-written sequences then cover the counters, saturation and async reset.
// ---------------------------------------------------------------------------
module tb_stage_skid_reg;

  localparam int CW = 8;
  localparam int DW = 16;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_ready;

  logic          in_ready,   h_in_ready;
  logic          out_valid,  h_out_valid;
  logic [CW-1:0] out_ctrl,   h_out_ctrl;
  logic [DW-1:0] out_data,   h_out_data;
  logic [1:0]    occupancy,  h_occupancy;
  logic [NW-1:0] bubble_cnt, h_bubble_cnt;
  logic [NW-1:0] flush_cnt,  h_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW), .CLR_DATA_ON_BUBBLE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW), .CLR_DATA_ON_BUBBLE(1'b0)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(h_out_valid), .out_ready(out_ready), .out_ctrl(h_out_ctrl),
    .out_data(h_out_data), .occupancy(h_occupancy),
    .bubble_cnt(h_bubble_cnt), .flush_cnt(h_flush_cnt)
  );

  // The data payload is derived from ctrl so a single field identifies a beat.
  function automatic logic [DW-1:0] mk(input logic [CW-1:0] c);
    return {c, ~c};
  endfunction

  typedef struct {
    logic          iv;
    logic [CW-1:0] ictrl;
    logic          fl;
    logic          ordy;
    logic          eov;
    logic [CW-1:0] ectrl;
    logic          eir;
    logic [1:0]    eocc;
  } vec_t;

  function automatic vec_t mkv(input logic iv, input logic [CW-1:0] ic, input logic fl,
                               input logic ordy, input logic eov, input logic [CW-1:0] ec,
                               input logic eir, input logic [1:0] eocc);
    vec_t v;
    v.iv = iv; v.ictrl = ic; v.fl = fl; v.ordy = ordy;
    v.eov = eov; v.ectrl = ec; v.eir = eir; v.eocc = eocc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [CW-1:0] c, input logic fl, input logic ordy);
    in_valid  = iv;
    in_ctrl   = iv ? c : 'x;
    in_data   = iv ? mk(c) : 'x;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Packs {out_valid, out_ctrl, out_data, in_ready, occupancy, bubble_cnt, flush_cnt}
  function automatic logic [63:0] all_out();
    return {28'h0, out_valid, out_ctrl, out_data, in_ready, occupancy, bubble_cnt, flush_cnt};
  endfunction

  vec_t tbl[23];
  logic ctrl_zero;

  initial begin
    // Streaming 1..8, then drain
    for (int k = 0; k < 8; k++)
      tbl[k] = mkv(1, 8'(k + 1), 0, 1, 1, 8'(k + 1), 1, 2'd1);
    tbl[8]  = mkv(0, 8'h00, 0, 1, 0, 8'h00, 1, 2'd0);
    // Backpressure A, B, C
    tbl[9]  = mkv(1, 8'hA1, 0, 0, 1, 8'hA1, 1, 2'd1);
    tbl[10] = mkv(1, 8'hB2, 0, 0, 1, 8'hA1, 0, 2'd2);
    tbl[11] = mkv(1, 8'hC3, 0, 0, 1, 8'hA1, 0, 2'd2);
    tbl[12] = mkv(1, 8'hC3, 0, 1, 1, 8'hB2, 1, 2'd1);
    tbl[13] = mkv(1, 8'hC3, 0, 1, 1, 8'hC3, 1, 2'd1);
    tbl[14] = mkv(0, 8'h00, 0, 1, 0, 8'h00, 1, 2'd0);
    tbl[15] = mkv(0, 8'h00, 0, 0, 0, 8'h00, 1, 2'd0);
    // Flush while full, with D offered in the flush cycle
    tbl[16] = mkv(1, 8'hE1, 0, 0, 1, 8'hE1, 1, 2'd1);
    tbl[17] = mkv(1, 8'hE2, 0, 0, 1, 8'hE1, 0, 2'd2);
    tbl[18] = mkv(1, 8'hDD, 1, 0, 0, 8'h00, 1, 2'd0);
    tbl[19] = mkv(0, 8'h00, 0, 1, 0, 8'h00, 1, 2'd0);
    // Flush with one entry while accept and pop are both active
    tbl[20] = mkv(1, 8'hF1, 0, 1, 1, 8'hF1, 1, 2'd1);
    tbl[21] = mkv(1, 8'hF2, 1, 1, 0, 8'h00, 1, 2'd0);
    tbl[22] = mkv(0, 8'h00, 0, 1, 0, 8'h00, 1, 2'd0);

    // Reset state
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    check("reset_state", all_out(), {28'h0, 1'b0, 8'h00, 16'h0000, 1'b1, 2'd0, 4'd0, 4'd0});
    rst = 1'b0;

    // Table vectors: expected outputs are checked right after the edge.
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].iv, tbl[i].ictrl, tbl[i].fl, tbl[i].ordy);
      step();
      check($sformatf("vec%0d", i),
            {28'h0, out_valid, out_ctrl, out_data, in_ready, occupancy},
            {28'h0, tbl[i].eov, tbl[i].ectrl, tbl[i].eov ? mk(tbl[i].ectrl) : 16'h0,
             tbl[i].eir, tbl[i].eocc});
    end

    // Flush counter: a flush while full counts, a flush while empty does not,
    // and a flush cycle is never counted as a bubble.
    do_reset();
    drive(1'b1, 8'h11, 1'b0, 1'b0); step();
    drive(1'b1, 8'h22, 1'b0, 1'b0); step();
    drive(1'b1, 8'h33, 1'b1, 1'b0); step();
    check("flush_full_cnt", {56'h0, flush_cnt, bubble_cnt}, {56'h0, 4'd1, 4'd0});
    drive(1'b0, '0, 1'b1, 1'b1); step();
    check("flush_empty_cnt", {56'h0, flush_cnt, bubble_cnt}, {56'h0, 4'd1, 4'd0});
    drive(1'b0, '0, 1'b0, 1'b1); step();
    check("bubble_after_flush", {56'h0, flush_cnt, bubble_cnt}, {56'h0, 4'd1, 4'd1});

    // Bubble saturation: one pop, then 19 bubble cycles into a 4-bit counter.
    do_reset();
    drive(1'b1, 8'h5A, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b1);
    ctrl_zero = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_ctrl !== 8'h00 || out_valid !== 1'b0) ctrl_zero = 1'b0;
    end
    check("bubble_ctrl_zero", {63'h0, ctrl_zero}, 64'h1);
    check("bubble_sat", {60'h0, bubble_cnt}, {60'h0, 4'hF});
    check("clr_data_zero", {48'h0, out_data}, 64'h0);
    check("hold_data", {40'h0, h_out_ctrl, h_out_data}, {40'h0, 8'h00, mk(8'h5A)});

    // Async reset between edges while full, then 1-cycle latency after release
    do_reset();
    drive(1'b1, 8'h71, 1'b0, 1'b0); step();
    drive(1'b1, 8'h72, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", all_out(), {28'h0, 1'b0, 8'h00, 16'h0000, 1'b1, 2'd0, 4'd0, 4'd0});
    step();
    rst = 1'b0;
    drive(1'b1, 8'h73, 1'b0, 1'b1); step();
    check("post_reset_accept", {39'h0, out_valid, out_ctrl, out_data, occupancy},
          {39'h0, 1'b1, 8'h73, mk(8'h73), 2'd1});
    drive(1'b0, '0, 1'b0, 1'b1); step();
    check("post_reset_drain", {47'h0, out_valid, out_data}, {47'h0, 1'b0, 16'h0000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stage_skid_reg.md
STAGE_SKID_REG -- requirements
Module: stage_skid_reg

Interface
REQ-001 Parameter CTRL_W, default 24, width of control payload (write-enable, op-selects); zeroed on bubble.
REQ-002 Parameter DATA_W, default 128, width of data payload (operands, immediate, pc+4).
REQ-003 Parameter CNT_W, default 16, width of each performance counter.
REQ-004 Parameter CLR_DATA_ON_BUBBLE, default 0; 1 = data payload also zeroed when an entry is cleared, 0 = data holds.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage can accept a beat this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control payload.
REQ-010 in_data  input  DATA_W  upstream data payload.
REQ-011 flush  input  1  synchronous kill of all held and incoming beats (control hazard).
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_ready  input  1  downstream accepts head this cycle.
REQ-014 out_ctrl  output  CTRL_W  head control payload; all-zero whenever out_valid=0.
REQ-015 out_data  output  DATA_W  head data payload.
REQ-016 occupancy  output  2  entries held: 0, 1 or 2.
REQ-017 bubble_cnt  output  CNT_W  cycles downstream consumed a bubble.
REQ-018 flush_cnt  output  CNT_W  flushes that discarded at least one held entry.

Function
REQ-019 Storage SHALL be two entries, main (head) and skid, each {valid, ctrl, data}; strict FIFO order.
REQ-020 accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-021 in_ready SHALL equal !skid.valid, driven from a register (no combinational path from out_ready).
REQ-022 out_valid/out_ctrl/out_data SHALL come directly from main registers; latency accept->out_valid = 1 cycle; throughput 1 beat/cycle when out_ready held high.
REQ-023 State EMPTY: accept -> ONE, main<=in.
REQ-024 State ONE: accept&pop -> ONE, main<=in; accept&!pop -> TWO, skid<=in; !accept&pop -> EMPTY; otherwise hold.
REQ-025 State TWO: no accept possible; pop -> ONE, main<=skid, skid cleared; otherwise hold all.
REQ-026 Cleared entry: valid=0, ctrl=0; data=0 if CLR_DATA_ON_BUBBLE=1, else data unchanged.
REQ-027 flush SHALL take priority over accept and pop: next cycle both entries cleared, occupancy=0, in_ready=1; a beat offered in the flush cycle is dropped; pop in flush cycle is still seen by downstream (head was valid that cycle).
REQ-028 occupancy SHALL equal main.valid + skid.valid; skid.valid=1 implies main.valid=1.
REQ-029 bubble_cnt SHALL increment when out_valid=0 & out_ready=1 & !flush; saturates at all-ones.
REQ-030 flush_cnt SHALL increment when flush=1 & occupancy!=0; saturates at all-ones.
REQ-031 in_ctrl/in_data SHALL be sampled only on accept; X on inputs while in_valid=0 SHALL NOT propagate.

Reset
REQ-032 On rst: main and skid valid=0, ctrl=0, data=0; occupancy=0; in_ready=1; out_valid=0; out_ctrl=0; out_data=0; both counters=0.
REQ-033 rst asserted mid-transfer SHALL discard all entries immediately with no beat emitted; first accept after release lands in main with 1-cycle latency.

Verification
REQ-034 Streaming: out_ready=1, beats ctrl=1..8 on consecutive cycles -> out_ctrl 1..8 on consecutive cycles one cycle later, occupancy<=1, in_ready always 1.
REQ-035 Backpressure: out_ready=0, offer A,B,C -> A in main, B in skid, in_ready=0, C held by upstream, occupancy=2; raise out_ready -> A,B,C emitted in order, no loss/duplication.
REQ-036 Flush while full: occupancy=2, flush=1 with in_valid=1 carrying D -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1, D never emitted, flush_cnt=1.
REQ-037 Flush while empty: occupancy=0, flush=1 -> flush_cnt unchanged (0); bubble_cnt unchanged that cycle.
REQ-038 Bubbles/saturation: CNT_W=4, in_valid=0, out_ready=1 for 20 cycles -> bubble_cnt=15 held, out_ctrl=0 throughout; with CLR_DATA_ON_BUBBLE=1 out_data=0 after last pop.
REQ-039 Async reset: occupancy=2, assert rst between edges -> outputs go to REQ-032 values before next clk edge.
